// File: rtl/mem_data_arbiter_if.sv
// Request/response handshake of both requesters plus the memory data-port control lines.
// The arbiter uses the slave modport; requesters (or a bench) use the master modport.
interface mem_data_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              r0_valid;
    logic              r0_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_we;
    logic [1:0]        r0_size;
    logic              r0_signed;
    logic [31:0]       r0_wdata;
    logic              r0_rsp_valid;

    logic              r1_valid;
    logic              r1_ready;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_we;
    logic [1:0]        r1_size;
    logic              r1_signed;
    logic [31:0]       r1_wdata;
    logic              r1_rsp_valid;

    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] data_addr;
    logic [1:0]        data_size;
    logic              mem_signed;

    modport slave (
        input  r0_valid, r0_addr, r0_we, r0_size, r0_signed, r0_wdata,
        input  r1_valid, r1_addr, r1_we, r1_size, r1_signed, r1_wdata,
        output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_rdata, rsp_err,
        output cs, we, data_addr, data_size, mem_signed
    );

    modport master (
        output r0_valid, r0_addr, r0_we, r0_size, r0_signed, r0_wdata,
        output r1_valid, r1_addr, r1_we, r1_size, r1_signed, r1_wdata,
        input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_rdata, rsp_err,
        input  cs, we, data_addr, data_size, mem_signed
    );
endinterface

// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter between the load/store unit (r0) and the debug loader (r1) for the
// unified memory's data port: alignment check, DATA_BUS tri-state, read-latency wait, response pulse.
module mem_data_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_data_arbiter_if.slave bus,
    inout  wire  [31:0]       data_bus
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              store_q, store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              drive_q, drive_d;
    logic              rsp0_q, rsp0_d;
    logic              rsp1_q, rsp1_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              gnt0, gnt1, sel;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we, req_sgn, req_bad;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0      = bus.r0_valid && (!bus.r1_valid || last_grant_q);
        gnt1      = bus.r1_valid && (!bus.r0_valid || !last_grant_q);
        sel       = gnt1;
        req_addr  = sel ? bus.r1_addr   : bus.r0_addr;
        req_we    = sel ? bus.r1_we     : bus.r0_we;
        req_size  = sel ? bus.r1_size   : bus.r0_size;
        req_sgn   = sel ? bus.r1_signed : bus.r0_signed;
        req_wdata = sel ? bus.r1_wdata  : bus.r0_wdata;
        req_bad   = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    assign bus.r0_ready = (state_q == IDLE) && gnt0;
    assign bus.r1_ready = (state_q == IDLE) && gnt1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        store_d      = store_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        rdata_d      = rdata_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        drive_d      = 1'b0;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d         = sel;
                    last_grant_d = sel;
                    if (req_bad) begin
                        state_d = FAULT;
                        rsp0_d  = !sel;
                        rsp1_d  = sel;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        store_d = req_we;
                        wdata_d = req_wdata;
                        addr_d  = req_addr;
                        size_d  = req_size;
                        sgn_d   = req_sgn;
                        cs_d    = 1'b1;
                        we_d    = req_we;
                        drive_d = req_we;
                    end
                end
            end
            ACCESS: begin
                if (store_q) begin
                    state_d = RESP;
                    rsp0_d  = !id_q;
                    rsp1_d  = id_q;
                    rdata_d = '0;
                end else begin
                    state_d = WAIT;
                    cs_d    = 1'b1;
                    cnt_d   = 3'(READ_LAT);
                end
            end
            // The memory drives sign/zero-extended load data; sample it as the count expires.
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                    rsp0_d  = !id_q;
                    rsp1_d  = id_q;
                    rdata_d = data_bus;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    cs_d  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            store_q      <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            drive_q      <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            store_q      <= store_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            drive_q      <= drive_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.cs           = cs_q;
    assign bus.we           = we_q;
    assign bus.data_addr    = addr_q;
    assign bus.data_size    = size_q;
    assign bus.mem_signed   = sgn_q;
    assign bus.r0_rsp_valid = rsp0_q;
    assign bus.r1_rsp_valid = rsp1_q;
    assign bus.rsp_err      = err_q;
    assign bus.rsp_rdata    = rdata_q;

    assign data_bus = drive_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Scoreboard bench: a request-level model predicts grants, memory contents, response data and
// response timing; a negedge monitor checks responses and data-port activity against it.
module tb_mem_data_arbiter;

    localparam int ADDR_W = 20;
    localparam int RL     = 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [31:0]       wdata;
    } req_t;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_data_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    wire [31:0] data_bus;

    mem_data_arbiter #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (RL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .data_bus (data_bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device on the data port: drives load data while selected for read, commits stores.
    logic [7:0]  dev_mem [0:255] = '{default: 8'h00};
    logic [7:0]  da;
    logic [31:0] rd_val;
    assign da = bus.data_addr[7:0];

    always_comb begin
        rd_val = {dev_mem[8'(da + 8'd3)], dev_mem[8'(da + 8'd2)], dev_mem[8'(da + 8'd1)], dev_mem[da]};
        case (bus.data_size)
            2'b00: rd_val = bus.mem_signed ? {{24{dev_mem[da][7]}}, dev_mem[da]} : {24'h0, dev_mem[da]};
            2'b01: rd_val = bus.mem_signed ? {{16{dev_mem[8'(da + 8'd1)][7]}}, dev_mem[8'(da + 8'd1)], dev_mem[da]}
                                           : {16'h0, dev_mem[8'(da + 8'd1)], dev_mem[da]};
            default: ;
        endcase
    end

    assign data_bus = (bus.cs && !bus.we) ? rd_val : 32'bz;

    always @(posedge clk) begin
        if (bus.cs && bus.we) begin
            for (int i = 0; i < (1 << bus.data_size); i++)
                dev_mem[8'(da + 8'(i))] <= data_bus[8*i +: 8];
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [0:255] = '{default: 8'h00};
    req_t pend0[$];
    req_t pend1[$];
    exp_t sb[$];
    int   last_g = 1;
    int   free_cyc = 0;
    int   win_lo = -1;
    int   win_hi = -2;
    logic win_we = 1'b0;
    logic [ADDR_W-1:0] win_addr = '0;
    logic [31:0] win_wdata = '0;
    bit   mon_en = 1'b1;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_access(input int id, input req_t r, input int hs, output exp_t e);
        int n;
        int a;
        logic [31:0] v;
        e.id    = id;
        e.err   = 1'b0;
        e.rdata = '0;
        a = int'(r.addr[7:0]);
        n = (r.size == 2'b11) ? 1 : (1 << r.size);
        if (r.size == 2'b11 || (int'(r.addr) % n) != 0) begin
            e.err = 1'b1;
            e.cyc = hs;
        end else if (r.we) begin
            for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = r.wdata[8*i +: 8];
            e.cyc = hs + 1;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 256]) << (8 * i));
            if (r.sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.cyc   = hs + 1 + RL;
        end
    endtask

    function automatic req_t mk(input int addr, input bit we, input int size, input bit sgn, input logic [31:0] wdata);
        req_t r;
        r.addr  = ADDR_W'(addr);
        r.we    = we;
        r.size  = 2'(size);
        r.sgn   = sgn;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.addr = ADDR_W'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
            if (r.size == 2'b01) r.addr[0] = 1'b0;
            if (r.size == 2'b10) r.addr[1:0] = 2'b00;
        end
        r.we    = 1'($urandom_range(0, 1));
        r.sgn   = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive_req(input int id, input bit v, input req_t r);
        if (id == 0) begin
            bus.r0_valid = v; bus.r0_addr = r.addr; bus.r0_we = r.we;
            bus.r0_size = r.size; bus.r0_signed = r.sgn; bus.r0_wdata = r.wdata;
        end else begin
            bus.r1_valid = v; bus.r1_addr = r.addr; bus.r1_we = r.we;
            bus.r1_size = r.size; bus.r1_signed = r.sgn; bus.r1_wdata = r.wdata;
        end
    endtask

    // Presents queued requests, predicts the grant each cycle and pushes expectations at the handshake.
    task automatic apply_stimulus(input int budget);
        int   k, g, hs;
        bit   v0, v1;
        req_t r;
        exp_t e;
        while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            k  = cyc;
            v0 = pend0.size() > 0;
            v1 = pend1.size() > 0;
            drive_req(0, v0, v0 ? pend0[0] : mk(0, 0, 0, 0, 0));
            drive_req(1, v1, v1 ? pend1[0] : mk(0, 0, 0, 0, 0));
            #1;
            g = -1;
            if (k >= free_cyc) begin
                if (v0 && v1) g = (last_g == 1) ? 0 : 1;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
            end
            if (v0) check_output("r0_ready", 32'(bus.r0_ready), 32'(g == 0));
            if (v1) check_output("r1_ready", 32'(bus.r1_ready), 32'(g == 1));
            @(posedge clk);
            if (g >= 0) begin
                hs = k + 1;
                r  = (g == 0) ? pend0.pop_front() : pend1.pop_front();
                model_access(g, r, hs, e);
                sb.push_back(e);
                last_g   = g;
                free_cyc = e.cyc + 1;
                if (!e.err) begin
                    win_lo    = hs;
                    win_hi    = e.cyc - 1;
                    win_we    = r.we;
                    win_addr  = r.addr;
                    win_wdata = r.wdata;
                end
            end
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        if (budget <= 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: pending r0=%0d r1=%0d responses=%0d", pend0.size(), pend1.size(), sb.size());
            pend0.delete();
            pend1.delete();
            sb.delete();
        end
    endtask

    // Monitor: response scoreboard plus chip-select/write-enable/address activity per cycle.
    exp_t mon_e;
    bit   ecs, ewe;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            ecs = (cyc >= win_lo) && (cyc <= win_hi);
            ewe = ecs && win_we && (cyc == win_lo);
            check_output("cs", 32'(bus.cs), 32'(ecs));
            check_output("we", 32'(bus.we), 32'(ewe));
            if (ecs) check_output("data_addr", 32'(bus.data_addr), 32'(win_addr));
            if (ewe) check_output("data_bus_store", data_bus, win_wdata);
            if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
                if (bus.r0_rsp_valid && bus.r1_rsp_valid) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL rsp_both: got both rsp_valid expected one (cycle %0d)", cyc);
                end else if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL rsp_unexpected: got rsp_valid expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("rsp_owner", 32'(bus.r1_rsp_valid), 32'(mon_e.id));
                    check_output("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                    check_output("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    check_output("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL rsp_missing: got no response expected one at cycle %0d (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        drive_req(0, 1'b0, mk(0, 0, 0, 0, 0));
        drive_req(1, 1'b0, mk(0, 0, 0, 0, 0));
        #1;
        check_output("rst_cs", 32'(bus.cs), 32'd0);
        check_output("rst_we", 32'(bus.we), 32'd0);
        check_output("rst_signed", 32'(bus.mem_signed), 32'd0);
        check_output("rst_rsp0", 32'(bus.r0_rsp_valid), 32'd0);
        check_output("rst_rsp1", 32'(bus.r1_rsp_valid), 32'd0);
        check_output("rst_err", 32'(bus.rsp_err), 32'd0);
        check_output("rst_rdata", bus.rsp_rdata, 32'd0);
        check_output("rst_addr", 32'(bus.data_addr), 32'd0);
        check_output("rst_size", 32'(bus.data_size), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pend0.push_back(mk('h13, 1, 0, 0, 32'h0000_00AA));
        pend0.push_back(mk('h13, 0, 0, 0, 32'h0));
        apply_stimulus(200);

        pend1.push_back(mk('h34, 1, 2, 0, 32'hDEAD_BEEF));
        pend1.push_back(mk('h34, 0, 2, 0, 32'h0));
        apply_stimulus(200);

        pend0.push_back(mk('h41, 1, 0, 0, 32'h0000_0080));
        pend0.push_back(mk('h41, 0, 0, 1, 32'h0));
        pend0.push_back(mk('h40, 1, 1, 0, 32'h0000_8123));
        pend0.push_back(mk('h40, 0, 1, 1, 32'h0));
        apply_stimulus(200);

        for (int i = 0; i < 2; i++) begin
            pend0.push_back(mk('h50 + 4*i, 1, 2, 0, 32'h1111_0000 + 32'(i)));
            pend1.push_back(mk('h58 + 4*i, 1, 2, 0, 32'h2222_0000 + 32'(i)));
        end
        apply_stimulus(200);

        pend0.push_back(mk('h22, 0, 1, 0, 32'h0));
        pend0.push_back(mk('h23, 0, 1, 0, 32'h0));
        pend0.push_back(mk('h36, 0, 2, 0, 32'h0));
        pend0.push_back(mk('h50, 1, 3, 0, 32'hFFFF_FFFF));
        pend0.push_back(mk('h50, 0, 2, 0, 32'h0));
        apply_stimulus(200);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) pend0.push_back(rand_req());
            else                           pend1.push_back(rand_req());
        end
        apply_stimulus(3000);

        // Reset in the middle of a load's wait phase: the access is dropped without a response.
        mon_en = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, mk('h34, 0, 2, 0, 32'h0));
        #1;
        check_output("mid_rst_ready", 32'(bus.r0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.r0_valid = 1'b0;
        @(negedge clk);
        check_output("wait_cs", 32'(bus.cs), 32'd1);
        check_output("wait_we", 32'(bus.we), 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_cs", 32'(bus.cs), 32'd0);
        check_output("mid_rst_we", 32'(bus.we), 32'd0);
        check_output("mid_rst_rsp0", 32'(bus.r0_rsp_valid), 32'd0);
        check_output("mid_rst_rsp1", 32'(bus.r1_rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        check_output("held_rst_rsp0", 32'(bus.r0_rsp_valid), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_g   = 1;
        free_cyc = 0;
        win_lo   = -1;
        win_hi   = -2;
        sb.delete();
        mon_en   = 1'b1;

        pend0.push_back(mk('h60, 1, 0, 0, 32'h0000_005A));
        pend1.push_back(mk('h61, 1, 0, 0, 32'h0000_00A5));
        pend0.push_back(mk('h60, 0, 1, 1, 32'h0));
        pend1.push_back(mk('h34, 0, 2, 0, 32'h0));
        apply_stimulus(200);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
